// File: rtl/burst_gen_pkg.sv
// Shared types, defaults and helpers for the operand burst generator.
// Parity support is enabled by defining BURST_GEN_PARITY_EN.
package burst_gen_pkg;

   localparam int W_DEF     = 9;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      INCR = 2'd0,
      SHL  = 2'd1,
      ROTL = 2'd2,
      ALT  = 2'd3
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      GEN  = 1'b1
   } state_e;

   function automatic logic [W_DEF-1:0] next_val(input op_e op, input logic [W_DEF-1:0] v);
      logic [W_DEF-1:0] r;
      r = v;
      case (op)
         INCR:    r = v + {{(W_DEF-1){1'b0}}, 1'b1};
         SHL:     r = {v[W_DEF-2:0], 1'b0};
         ROTL:    r = {v[W_DEF-2:0], v[W_DEF-1]};
         ALT:     r = ~v;
         default: r = v;
      endcase
      return r;
   endfunction

   // Even parity over one beat {x, y, last}.
   function automatic logic beat_par(input logic [2*W_DEF:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/burst_fifo.sv
// Synchronous FIFO with registered head data and valid; full is taken from
// registered occupancy only, so a same-cycle pop never frees a slot for a push.
module burst_fifo #(
   parameter int DW    = 19,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic          valid,
   output logic [DW-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] head_q, head_d;
   logic          valid_q;
   logic          do_push_s, do_pop_s;

   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == {CW{1'b0}});
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && valid_q;
   assign valid     = valid_q;
   assign head      = head_q;

   // Next pointers, occupancy and head selection.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (do_push_s) begin
         wptr_d = wptr_q + AW'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (do_pop_s) begin
         rptr_d = rptr_q + AW'(1);
      end else begin
         rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      // The pushed word becomes the head when nothing older survives this edge.
      if (cnt_d == {CW{1'b0}}) begin
         head_d = head_q;
      end else if (do_push_s && (cnt_q == (do_pop_s ? CW'(1) : CW'(0)))) begin
         head_d = wdata;
      end else begin
         head_d = mem_q[rptr_d];
      end
   end

   // Storage, pointers and registered head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         wptr_q  <= {AW{1'b0}};
         rptr_q  <= {AW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         head_q  <= {DW{1'b0}};
         valid_q <= 1'b0;
      end else begin
         if (do_push_s) begin
            mem_q[wptr_q] <= wdata;
         end
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         valid_q <= (cnt_d != {CW{1'b0}});
      end
   end

endmodule

// File: rtl/burst_gen.sv
// Expands one command into a burst of x/y operand pairs and buffers them.
// Define BURST_GEN_PARITY_EN to add the out_par port and stored parity bit.
module burst_gen
   import burst_gen_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_seed,
   input  logic [3:0]   cmd_len,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_y,
   output logic         out_last
`ifdef BURST_GEN_PARITY_EN
   ,output logic        out_par
`endif
);

`ifdef BURST_GEN_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int DW = 2 * W + 1 + PW;

   state_e        state_q;
   op_e           op_q;
   logic [W-1:0]  cur_q, prev_q;
   logic [3:0]    cnt_q;
   logic          cmd_ready_q;
   logic          full_s, empty_s, push_s, pop_s, last_s;
   logic [DW-1:0] wdata_s, head_s;

   assign last_s = (cnt_q == 4'd0);
   assign push_s = (state_q == GEN) && !full_s;
   assign pop_s  = out_ready && !empty_s;

`ifdef BURST_GEN_PARITY_EN
   assign wdata_s = {beat_par({cur_q, prev_q, last_s}), cur_q, prev_q, last_s};
   assign out_par = head_s[DW-1];
`else
   assign wdata_s = {cur_q, prev_q, last_s};
`endif
   assign out_x     = head_s[2*W:W+1];
   assign out_y     = head_s[W:1];
   assign out_last  = head_s[0];
   assign cmd_ready = cmd_ready_q;

   // Command FSM and generator registers; everything holds while the FIFO is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= INCR;
         cur_q       <= {W{1'b0}};
         prev_q      <= {W{1'b0}};
         cnt_q       <= 4'd0;
         cmd_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  op_q        <= op_e'(cmd_op);
                  cur_q       <= cmd_seed;
                  prev_q      <= {W{1'b0}};
                  cnt_q       <= cmd_len;
                  state_q     <= GEN;
                  cmd_ready_q <= 1'b0;
               end
            end
            GEN: begin
               if (!full_s) begin
                  prev_q <= cur_q;
                  cur_q  <= next_val(op_q, cur_q);
                  cnt_q  <= cnt_q - 4'd1;
                  if (last_s) begin
                     state_q     <= IDLE;
                     cmd_ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   burst_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (wdata_s),
      .pop   (pop_s),
      .full  (full_s),
      .empty (empty_s),
      .valid (out_valid),
      .head  (head_s)
   );

endmodule
